mig_app_responder: RTL

MIG_APP_RESPONDER -- requirements
Module: mig_app_responder

---
 rtl/mig_app_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mig_app_responder.sv
// Application-interface responder for a memory controller: on-chip storage
// behind the command / write-data / read-data / maintenance handshakes.
//
// state        | meaning
// S_INIT       | calibration countdown after reset release
// S_READY      | accepting commands when nothing else is pending
// S_WAIT_WDATA | write command taken with an empty data FIFO, waiting for a beat
// S_MAINT      | serving a refresh or ZQ request (two cycles, then ack)
module mig_app_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int READ_LATENCY   = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   i_app_addr,
  input  logic [2:0]              i_app_cmd,
  input  logic                    i_app_en,
  output logic                    o_app_rdy,
  input  logic [DATA_WIDTH-1:0]   i_app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] i_app_wdf_mask,
  input  logic                    i_app_wdf_wren,
  input  logic                    i_app_wdf_end,
  output logic                    o_app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   o_app_rd_data,
  output logic                    o_app_rd_data_valid,
  output logic                    o_app_rd_data_end,
  input  logic                    i_app_ref_req,
  output logic                    o_app_ref_ack,
  input  logic                    i_app_zq_req,
  output logic                    o_app_zq_ack,
  input  logic                    i_app_sr_req,
  output logic                    o_app_sr_active,
  output logic                    o_init_calib_complete
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int CALIB_W    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  typedef enum logic [1:0] {S_INIT, S_READY, S_WAIT_WDATA, S_MAINT} state_t;

  state_t                    state, state_nxt;
  logic [CALIB_W-1:0]        calib_cnt;
  logic                      maint_cnt;
  logic                      maint_is_ref;
  logic                      ref_pend, zq_pend;
  logic                      app_rdy;
  logic [MEM_DEPTH_LOG2-1:0] addr_idx, wait_idx, wr_idx;

  logic [DATA_WIDTH-1:0]     fifo_data [4];
  logic [MASK_WIDTH-1:0]     fifo_mask [4];
  logic [1:0]                fifo_wr_ptr, fifo_rd_ptr;
  logic [2:0]                fifo_cnt;
  logic                      fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [MASK_WIDTH-1:0]     wr_mask;

  logic [READ_LATENCY-1:0]   rd_vld;
  logic [DATA_WIDTH-1:0]     rd_pipe [READ_LATENCY];

  logic accept, rd_accept, wr_accept, beat_in, wait_direct, maint_done;

  // Offset bits below the word and aliased upper address bits are ignored;
  // the end-of-burst flag carries no information for single-beat writes.
  logic unused_bits;
  assign unused_bits = ^{i_app_addr[2:0], i_app_addr[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2], i_app_wdf_end};

  assign addr_idx    = i_app_addr[3 +: MEM_DEPTH_LOG2];
  assign fifo_empty  = (fifo_cnt == 3'd0);
  assign fifo_full   = (fifo_cnt == 3'd4);
  assign accept      = app_rdy & i_app_en;
  assign rd_accept   = accept & (i_app_cmd == CMD_READ);
  assign wr_accept   = accept & (i_app_cmd == CMD_WRITE);
  assign beat_in     = i_app_wdf_wren & o_app_wdf_rdy;
  // A beat arriving while waiting on an empty FIFO bypasses the FIFO.
  assign wait_direct = (state == S_WAIT_WDATA) & fifo_empty & beat_in;
  assign fifo_pop    = (wr_accept | (state == S_WAIT_WDATA)) & ~fifo_empty;
  assign fifo_push   = beat_in & ~wait_direct;
  assign mem_we      = fifo_pop | wait_direct;
  assign wr_idx      = (state == S_WAIT_WDATA) ? wait_idx : addr_idx;
  assign wr_data     = wait_direct ? i_app_wdf_data : fifo_data[fifo_rd_ptr];
  assign wr_mask     = wait_direct ? i_app_wdf_mask : fifo_mask[fifo_rd_ptr];
  assign maint_done  = (state == S_MAINT) & (maint_cnt == 1'b0);

  // Write-data ready is held low while reset is asserted.
  assign o_app_wdf_rdy       = i_rst_n & ~fifo_full;
  assign o_app_rdy           = app_rdy;
  assign o_app_rd_data       = rd_pipe[READ_LATENCY-1];
  assign o_app_rd_data_valid = rd_vld[READ_LATENCY-1];
  assign o_app_rd_data_end   = rd_vld[READ_LATENCY-1];

  // Next-state and command-ready decode.
  always_comb begin
    state_nxt = state;
    app_rdy   = 1'b0;
    case (state)
      S_INIT: if (calib_cnt == '0) state_nxt = S_READY;
      S_READY: begin
        app_rdy = ~ref_pend & ~zq_pend & ~o_app_sr_active;
        if (wr_accept && fifo_empty)                     state_nxt = S_WAIT_WDATA;
        else if ((ref_pend || zq_pend) && !o_app_sr_active) state_nxt = S_MAINT;
      end
      S_WAIT_WDATA: if (!fifo_empty || beat_in) state_nxt = S_READY;
      S_MAINT:      if (maint_cnt == 1'b0)      state_nxt = S_READY;
      default:      state_nxt = S_INIT;
    endcase
  end

  // State, calibration, maintenance and self-refresh registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= S_INIT;
      calib_cnt             <= CALIB_W'(CALIB_CYCLES - 1);
      o_init_calib_complete <= 1'b0;
      maint_cnt             <= 1'b0;
      maint_is_ref          <= 1'b0;
      ref_pend              <= 1'b0;
      zq_pend               <= 1'b0;
      o_app_ref_ack         <= 1'b0;
      o_app_zq_ack          <= 1'b0;
      o_app_sr_active       <= 1'b0;
      wait_idx              <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        if (calib_cnt == '0) o_init_calib_complete <= 1'b1;
        else                 calib_cnt <= calib_cnt - 1'b1;
      end
      if (state == S_READY && state_nxt == S_MAINT) begin
        maint_cnt    <= 1'b1;
        maint_is_ref <= ref_pend;
      end else if (state == S_MAINT && maint_cnt != 1'b0) begin
        maint_cnt <= 1'b0;
      end
      o_app_ref_ack <= maint_done & maint_is_ref;
      o_app_zq_ack  <= maint_done & ~maint_is_ref;
      if (i_app_ref_req)                    ref_pend <= 1'b1;
      else if (maint_done && maint_is_ref)  ref_pend <= 1'b0;
      if (i_app_zq_req)                     zq_pend  <= 1'b1;
      else if (maint_done && !maint_is_ref) zq_pend  <= 1'b0;
      if (!i_app_sr_req)         o_app_sr_active <= 1'b0;
      else if (state == S_READY) o_app_sr_active <= 1'b1;
      if (state_nxt == S_WAIT_WDATA && state == S_READY) wait_idx <= addr_idx;
    end
  end

  // Write FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_wr_ptr <= 2'd0;
      fifo_rd_ptr <= 2'd0;
      fifo_cnt    <= 3'd0;
    end else begin
      if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
      if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + 3'd1;
      else if (!fifo_push && fifo_pop) fifo_cnt <= fifo_cnt - 3'd1;
    end
  end

  // Write FIFO payload; contents are meaningless outside the occupied window.
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_data[fifo_wr_ptr] <= i_app_wdf_data;
      fifo_mask[fifo_wr_ptr] <= i_app_wdf_mask;
    end
  end

  // Byte-masked storage write; storage survives reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline: storage sampled at accept, delivered READ_LATENCY cycles later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_vld     <= {rd_vld[READ_LATENCY-2:0], rd_accept};
      rd_pipe[0] <= mem[addr_idx];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

endmodule
